// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its HI/LO registers.
package muldiv_pkg;

    // Operation codes as presented on the op port; 6 and 7 are reserved no-ops.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Quotient reported for a zero divisor; wide enough to be sliced for any width up to 64.
    localparam logic [63:0] DIV0_QUOT = '1;

    // True for the four iterative operations (MULT, MULTU, DIV, DIVU).
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // True for the two divide operations.
    function automatic logic is_divide(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: the accumulator high half is the running partial product and the
// low half the not-yet-consumed multiplier bits (shift-add, LSB first).
// Divide: the high half is the partial remainder and the low half holds the
// remaining dividend bits, into which quotient bits are shifted (restoring).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Compute both the shift-add and the trial-subtract step, then pick by mode.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        partial  = acc[2*WIDTH-1:WIDTH-1];
        fits     = (partial >= {1'b0, opnd});
        diff     = partial[WIDTH-1:0] - opnd;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            acc_next = {(fits ? diff : partial[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are captured as magnitudes at issue; WIDTH radix-2 steps run in RUN,
// and FIX applies result signs before HI/LO are written and done is pulsed.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               accept;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign busy = (state != S_IDLE);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (is_div),
        .acc_next (acc_step)
    );

    // Decode an accepted issue and form operand magnitudes for signed ops.
    always_comb begin
        accept    = (state == S_IDLE) && start && is_muldiv(op);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        abs_a     = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        abs_b     = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on issue, RUN for WIDTH steps, one FIX cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Iteration datapath: capture operands and sign flags at issue, step in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_div   <= is_divide(op);
                        opnd     <= is_divide(op) ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (is_divide(op) ? abs_a : abs_b)};
                        neg_q    <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_r    <= is_signed && rs_data[WIDTH-1];
                        div_zero <= (rt_data == '0);
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sign correction of the finished magnitudes; a zero divisor forces an all-ones quotient.
    always_comb begin
        prod_fixed = neg_q ? -acc : acc;
        rem_fixed  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        quot_fixed = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div_zero) begin
            quot_fixed = DIV0_QUOT[WIDTH-1:0];
        end
    end

    // HI/LO registers and the done pulse; only MT ops and FIX ever change HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_out <= '0;
            lo_out <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == S_IDLE) && start && (op == OP_MTHI)) begin
                hi_out <= rs_data;
            end
            if ((state == S_IDLE) && start && (op == OP_MTLO)) begin
                lo_out <= rs_data;
            end
            if (state == S_FIX) begin
                done <= 1'b1;
                if (is_div) begin
                    hi_out <= rem_fixed;
                    lo_out <= quot_fixed;
                end else begin
                    hi_out <= prod_fixed[2*WIDTH-1:WIDTH];
                    lo_out <= prod_fixed[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the general-purpose register file. It consumes the rs/rt read ports (data_out1/data_out2) in the ID/EX stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Presents HI/LO to the EX-stage result mux for MFHI/MFLO.
- Raises busy so the hazard unit stalls MFHI/MFLO and any new mul/div issue.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  issue strobe; sampled only in IDLE.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op).
- rs_data  in  WIDTH  operand A / dividend / MT source (from data_out1).
- rt_data  in  WIDTH  operand B / divisor (from data_out2).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset: one clock with rst=1 forces IDLE, hi_out=0, lo_out=0, busy=0, done=0, counter=0. rst has priority over everything, including mid-operation; a partial result is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, op MTHI/MTLO: HI (or LO) <= rs_data at that edge. Stay IDLE; busy and done stay 0.
- IDLE, start=1, op 0-3:
  - Latch |A| and |B| (unsigned ops use raw values), the result-sign flags and op; clear the 2*WIDTH accumulator.
  - Go to RUN, counter=0.
- IDLE, start=1, op 6/7: ignored.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th step (counter == WIDTH-1), go to FIX.
- FIX: apply signs, register HI/LO, pulse done for the next cycle, return to IDLE.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Latency: with start sampled high in cycle N:
  - busy=1 in cycles N+1..N+33.
  - hi_out/lo_out new and done=1 in cycle N+34, with busy=0 in that cycle.
- Back-to-back issue: a new start is accepted in the done cycle (N+34).
- start while busy is ignored. The hazard unit must not depend on queuing.
- Multiply results: HI = product[2W-1:W], LO = product[W-1:0].
- Divide results: LO = quotient, HI = remainder.
- Divide by zero (rt=0): LO = all ones, HI = rs_data. Applies to both signed and unsigned; no exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Operands are captured at issue, so later changes to rs_data/rt_data during RUN have no effect.
- hi_out/lo_out are held constant during RUN/FIX; they never show intermediate values.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT..OP_MTLO;
  - FSM state encodings S_IDLE, S_RUN, S_FIX;
  - DIV0_QUOT = all-ones constant.
- Optional sub-module muldiv_step: a purely combinational single iteration that maps accumulator, operand and mode to the next accumulator. It keeps the FSM/HI-LO top readable and is testable alone.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> done at N+34, HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high exactly N+1..N+33.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle with done=0.
- Issue MULT 5×7, pulse start with DIVU at N+10 and assert rst at N+20 -> start ignored, then hi=lo=0, busy=0, done never pulses.
